alu_issue: RTL and testbench

- Execute-stage initiator for `alu`: accepts decoded-operand RV32I instructions from the register-read stage over a valid/ready handshake.
- Translates each instruction into `ALU_CTRL_*` codes plus operands, and drives the ALU's clk/en/a/b/ctrl interface.
- Pairs the ALU's registered y with the instruction's metadata and returns one result beat per instruction over a valid/ready handshake.
- Covers OP, OP-IMM, LUI, AUIPC and BRANCH.

---
 rtl/alu_issue.sv | 247 ++++++++++++++++++++++++
 tb/tb_alu_issue.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_issue.sv
// alu_issue: execute-stage initiator for the shared ALU.
//
// Takes decoded-operand RV32I instructions (OP, OP-IMM, LUI, AUIPC, BRANCH)
// over a valid/ready handshake, translates each into an ALU control code and
// operands, and returns one result beat per instruction. The beat pairs the
// ALU's registered y with the instruction's metadata.
//
// Pipeline:
//   S1 - registered ALU inputs (alu_a/alu_b/alu_ctrl) and the instruction's
//        metadata.
//   S2 - metadata of the op whose result currently sits in the ALU's y register.
//
// Ports:
//   clk, rst_n        clock (shared with the ALU), async active-low reset
//   flush             synchronous kill of everything in flight
//   ins_*             instruction channel (valid/ready, instr, pc, rs1/rs2 data)
//   alu_en/a/b/ctrl   drive the ALU; alu_y is its registered result
//   res_*             result channel (valid/ready plus data and metadata)

package alu_issue_pkg;
  localparam logic [7:0] ALU_CTRL_ADD        = 8'd0;
  localparam logic [7:0] ALU_CTRL_SUB        = 8'd1;
  localparam logic [7:0] ALU_CTRL_SUB2       = 8'd2;
  localparam logic [7:0] ALU_CTRL_LSFT       = 8'd3;
  localparam logic [7:0] ALU_CTRL_RSFT       = 8'd4;
  localparam logic [7:0] ALU_CTRL_RSFTA      = 8'd5;
  localparam logic [7:0] ALU_CTRL_AND        = 8'd6;
  localparam logic [7:0] ALU_CTRL_OR         = 8'd7;
  localparam logic [7:0] ALU_CTRL_XOR        = 8'd8;
  localparam logic [7:0] ALU_CTRL_EQ         = 8'd9;
  localparam logic [7:0] ALU_CTRL_NEQ        = 8'd10;
  localparam logic [7:0] ALU_CTRL_LESS       = 8'd11;
  localparam logic [7:0] ALU_CTRL_LESS_SIGN  = 8'd12;
  localparam logic [7:0] ALU_CTRL_GRTEQ      = 8'd13;
  localparam logic [7:0] ALU_CTRL_GRTEQ_SIGN = 8'd14;
endpackage

module alu_issue
  import alu_issue_pkg::*;
#(
  parameter int CTRL_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              ins_valid,
  output logic              ins_ready,
  input  logic [31:0]       ins_instr,
  input  logic [DATA_W-1:0] ins_pc,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  output logic              alu_en,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CTRL_W-1:0] alu_ctrl,
  input  logic [DATA_W-1:0] alu_y,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [DATA_W-1:0] res_data,
  output logic [4:0]        res_rd,
  output logic              res_wb,
  output logic              res_branch,
  output logic              res_taken,
  output logic [DATA_W-1:0] res_target,
  output logic              res_illegal
);

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] F7_ZERO    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;

  // Shared funct3 map for OP and OP-IMM (funct7 qualifies SUB/SRA separately).
  function automatic logic [7:0] f3_ctrl(input logic [2:0] f3);
    case (f3)
      3'b000:  return ALU_CTRL_ADD;
      3'b001:  return ALU_CTRL_LSFT;
      3'b010:  return ALU_CTRL_LESS_SIGN;
      3'b011:  return ALU_CTRL_LESS;
      3'b100:  return ALU_CTRL_XOR;
      3'b101:  return ALU_CTRL_RSFT;
      3'b110:  return ALU_CTRL_OR;
      default: return ALU_CTRL_AND;
    endcase
  endfunction

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [DATA_W-1:0] imm_i, imm_u, imm_b;

  assign opcode = ins_instr[6:0];
  assign funct3 = ins_instr[14:12];
  assign funct7 = ins_instr[31:25];
  assign imm_i  = {{20{ins_instr[31]}}, ins_instr[31:20]};
  assign imm_u  = {ins_instr[31:12], 12'b0};
  assign imm_b  = {{20{ins_instr[31]}}, ins_instr[7], ins_instr[30:25],
                   ins_instr[11:8], 1'b0};

  logic [DATA_W-1:0] d_a, d_b, d_target;
  logic [7:0]        d_ctrl;
  logic [4:0]        d_rd;
  logic              d_wb, d_branch, d_illegal;

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the case leaves one unassigned (which would infer a latch).
    d_a       = '0;
    d_b       = '0;
    d_ctrl    = ALU_CTRL_ADD;
    d_rd      = ins_instr[11:7];
    d_branch  = 1'b0;
    d_target  = '0;
    d_illegal = 1'b0;
    case (opcode)
      OPC_OP: begin
        d_a = rs1_data;
        d_b = rs2_data;
        if (funct7 == F7_ZERO)                         d_ctrl = f3_ctrl(funct3);
        else if (funct7 == F7_ALT && funct3 == 3'b000) d_ctrl = ALU_CTRL_SUB;
        else if (funct7 == F7_ALT && funct3 == 3'b101) d_ctrl = ALU_CTRL_RSFTA;
        else                                           d_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        d_a    = rs1_data;
        d_b    = imm_i;
        d_ctrl = f3_ctrl(funct3);
        // Shifts take only the 5-bit shamt; the upper imm bits are funct7.
        if (funct3 == 3'b001) begin
          d_b = DATA_W'(ins_instr[24:20]);
          if (funct7 != F7_ZERO) d_illegal = 1'b1;
        end else if (funct3 == 3'b101) begin
          d_b = DATA_W'(ins_instr[24:20]);
          if (funct7 == F7_ALT)        d_ctrl    = ALU_CTRL_RSFTA;
          else if (funct7 != F7_ZERO)  d_illegal = 1'b1;
        end
      end
      OPC_LUI: begin
        d_b = imm_u;
      end
      OPC_AUIPC: begin
        d_a = ins_pc;
        d_b = imm_u;
      end
      OPC_BRANCH: begin
        d_a      = rs1_data;
        d_b      = rs2_data;
        d_rd     = 5'd0;
        d_branch = 1'b1;
        d_target = ins_pc + imm_b;
        case (funct3)
          3'b000:  d_ctrl = ALU_CTRL_EQ;
          3'b001:  d_ctrl = ALU_CTRL_NEQ;
          3'b100:  d_ctrl = ALU_CTRL_LESS_SIGN;
          3'b101:  d_ctrl = ALU_CTRL_GRTEQ_SIGN;
          3'b110:  d_ctrl = ALU_CTRL_LESS;
          3'b111:  d_ctrl = ALU_CTRL_GRTEQ;
          default: d_illegal = 1'b1;
        endcase
      end
      default: d_illegal = 1'b1;
    endcase
    // Illegal encodings still flow through as a harmless 0+0 so they produce a beat.
    if (d_illegal) begin
      d_a      = '0;
      d_b      = '0;
      d_ctrl   = ALU_CTRL_ADD;
      d_rd     = 5'd0;
      d_branch = 1'b0;
      d_target = '0;
    end
    d_wb = !d_branch && !d_illegal && (d_rd != 5'd0);
  end

  logic              s1_valid, s2_valid;
  logic [4:0]        s1_rd;
  logic              s1_wb, s1_branch, s1_illegal;
  logic [DATA_W-1:0] s1_target;
  logic              advance, accept;

  assign advance   = s1_valid && (!s2_valid || res_ready) && !flush;
  assign ins_ready = (!s1_valid || advance) && !flush;
  assign accept    = ins_valid && ins_ready;
  assign alu_en    = advance;

  // S1: decoded ALU inputs drive the ALU directly from these registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: non-blocking assignments for all state so every register samples
      // pre-edge values, independent of block evaluation order.
      s1_valid   <= 1'b0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_ctrl   <= CTRL_W'(ALU_CTRL_ADD);
      s1_rd      <= 5'd0;
      s1_wb      <= 1'b0;
      s1_branch  <= 1'b0;
      s1_target  <= '0;
      s1_illegal <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid   <= 1'b1;
      alu_a      <= d_a;
      alu_b      <= d_b;
      alu_ctrl   <= CTRL_W'(d_ctrl);
      s1_rd      <= d_rd;
      s1_wb      <= d_wb;
      s1_branch  <= d_branch;
      s1_target  <= d_target;
      s1_illegal <= d_illegal;
    end else if (advance) begin
      s1_valid <= 1'b0;
    end
  end

  // S2: metadata loads on the same edge the ALU captures y.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid    <= 1'b0;
      res_rd      <= 5'd0;
      res_wb      <= 1'b0;
      res_branch  <= 1'b0;
      res_target  <= '0;
      res_illegal <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (advance) begin
      s2_valid    <= 1'b1;
      res_rd      <= s1_rd;
      res_wb      <= s1_wb;
      res_branch  <= s1_branch;
      res_target  <= s1_target;
      res_illegal <= s1_illegal;
    end else if (res_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign res_valid = s2_valid;
  assign res_data  = alu_y;
  assign res_taken = res_branch && alu_y[0];

endmodule

// File: tb/tb_alu_issue.sv
// Directed bench for alu_issue with a behavioural ALU model (registered y,
// holds while en=0). Expected values are hand-computed constants.
module tb_alu_issue;
  import alu_issue_pkg::*;

  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_LUI = 7'b0110111;
  localparam logic [6:0] OP_AUI = 7'b0010111;

  logic        clk = 1'b0;
  logic        rst_n, flush, ins_valid, ins_ready;
  logic [31:0] ins_instr, ins_pc, rs1_data, rs2_data;
  logic        alu_en;
  logic [31:0] alu_a, alu_b;
  logic [7:0]  alu_ctrl;
  logic [31:0] alu_y = '0;
  logic        res_valid, res_ready;
  logic [31:0] res_data, res_target;
  logic [4:0]  res_rd;
  logic        res_wb, res_branch, res_taken, res_illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_issue #(.CTRL_W(8), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_instr(ins_instr),
    .ins_pc(ins_pc), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .alu_en(alu_en), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_y(alu_y), .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_rd(res_rd), .res_wb(res_wb),
    .res_branch(res_branch), .res_taken(res_taken),
    .res_target(res_target), .res_illegal(res_illegal)
  );

  // ALU model: y registered, updated only when en=1.
  always @(posedge clk) begin
    if (alu_en) begin
      case (alu_ctrl)
        ALU_CTRL_ADD:        alu_y <= alu_a + alu_b;
        ALU_CTRL_SUB:        alu_y <= alu_a - alu_b;
        ALU_CTRL_LSFT:       alu_y <= alu_a << alu_b[4:0];
        ALU_CTRL_RSFT:       alu_y <= alu_a >> alu_b[4:0];
        ALU_CTRL_RSFTA:      alu_y <= $signed(alu_a) >>> alu_b[4:0];
        ALU_CTRL_AND:        alu_y <= alu_a & alu_b;
        ALU_CTRL_OR:         alu_y <= alu_a | alu_b;
        ALU_CTRL_XOR:        alu_y <= alu_a ^ alu_b;
        ALU_CTRL_EQ:         alu_y <= {31'b0, alu_a == alu_b};
        ALU_CTRL_NEQ:        alu_y <= {31'b0, alu_a != alu_b};
        ALU_CTRL_LESS:       alu_y <= {31'b0, alu_a < alu_b};
        ALU_CTRL_LESS_SIGN:  alu_y <= {31'b0, $signed(alu_a) < $signed(alu_b)};
        ALU_CTRL_GRTEQ:      alu_y <= {31'b0, alu_a >= alu_b};
        ALU_CTRL_GRTEQ_SIGN: alu_y <= {31'b0, $signed(alu_a) >= $signed(alu_b)};
        default:             alu_y <= 32'hDEAD_BEEF;
      endcase
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {f7, rs2, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
      input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [4:0] rd,
      input logic [6:0] op);
    return {imm, rd, op};
  endfunction

  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
      input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_beat(input string tag, input logic [31:0] data, input logic [4:0] rd,
      input logic wb, input logic br, input logic tk, input logic [31:0] tgt, input logic ill);
    chk({tag, ".valid"},   32'(res_valid),   32'd1);
    chk({tag, ".data"},    res_data,         data);
    chk({tag, ".rd"},      32'(res_rd),      32'(rd));
    chk({tag, ".wb"},      32'(res_wb),      32'(wb));
    chk({tag, ".branch"},  32'(res_branch),  32'(br));
    chk({tag, ".taken"},   32'(res_taken),   32'(tk));
    chk({tag, ".target"},  res_target,       tgt);
    chk({tag, ".illegal"}, 32'(res_illegal), 32'(ill));
  endtask

  // Called at a negedge with res_ready=1; returns at the negedge where the beat is visible.
  task automatic send(input logic [31:0] instr, input logic [31:0] pc,
      input logic [31:0] r1, input logic [31:0] r2);
    ins_valid = 1'b1;
    ins_instr = instr;
    ins_pc    = pc;
    rs1_data  = r1;
    rs2_data  = r2;
    @(negedge clk);
    ins_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic offer(input logic [31:0] instr, input logic [31:0] r1, input logic [31:0] r2);
    ins_valid = 1'b1;
    ins_instr = instr;
    ins_pc    = 32'h0;
    rs1_data  = r1;
    rs2_data  = r2;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; ins_valid = 1'b0; res_ready = 1'b1;
    ins_instr = '0; ins_pc = '0; rs1_data = '0; rs2_data = '0;
    #2;
    chk("reset.res_valid", 32'(res_valid), 32'd0);
    chk("reset.alu_en",    32'(alu_en),    32'd0);
    chk("reset.ins_ready", 32'(ins_ready), 32'd1);
    chk("reset.alu_a",     alu_a,          32'd0);
    chk("reset.alu_ctrl",  32'(alu_ctrl),  32'(ALU_CTRL_ADD));
    chk("reset.res_wb",    32'(res_wb),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // ADD x5,x1,x2 : 7 + 0xFFFFFFFE = 5, beat one edge after accept.
    offer(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd5, OP_R), 32'd7, 32'hFFFF_FFFE);
    #1 chk("add.ins_ready", 32'(ins_ready), 32'd1);
    @(negedge clk);
    ins_valid = 1'b0;
    chk("add.s1.alu_en",    32'(alu_en),    32'd1);
    chk("add.s1.res_valid", 32'(res_valid), 32'd0);
    chk("add.s1.alu_b",     alu_b,          32'hFFFF_FFFE);
    @(negedge clk);
    check_beat("add", 32'd5, 5'd5, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);

    // ADD x0 : legal but no writeback.
    send(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd0, OP_R), 32'd0, 32'd3, 32'd4);
    check_beat("add_x0", 32'd7, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);

    // SRAI x3,x4,4 and the same with a bad funct7.
    send(enc_i({7'b0100000, 5'd4}, 5'd4, 3'b101, 5'd3, OP_I), 32'd0, 32'h8000_0000, 32'd0);
    check_beat("srai", 32'hF800_0000, 5'd3, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    send(enc_i({7'b0000001, 5'd4}, 5'd4, 3'b101, 5'd3, OP_I), 32'd0, 32'h8000_0000, 32'd0);
    chk("srai_bad.illegal", 32'(res_illegal), 32'd1);
    chk("srai_bad.data",    res_data,         32'd0);
    chk("srai_bad.wb",      32'(res_wb),      32'd0);
    chk("srai_bad.valid",   32'(res_valid),   32'd1);

    // SLTI x9,x1,-1 with rs1=-2 : sign-extended immediate, -2 < -1.
    send(enc_i(12'hFFF, 5'd1, 3'b010, 5'd9, OP_I), 32'd0, 32'hFFFF_FFFE, 32'd0);
    check_beat("slti", 32'd1, 5'd9, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);

    // Branches at pc=0x100, imm_b=-8 -> target 0xF8.
    send(enc_b(13'h1FF8, 5'd2, 5'd1, 3'b100), 32'h100, 32'hFFFF_FFFF, 32'd1);
    check_beat("blt", 32'd1, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0000_00F8, 1'b0);
    send(enc_b(13'h1FF8, 5'd2, 5'd1, 3'b111), 32'h100, 32'hFFFF_FFFF, 32'd1);
    check_beat("bgeu", 32'd1, 5'd0, 1'b0, 1'b1, 1'b1, 32'h0000_00F8, 1'b0);
    send(enc_b(13'h1FF8, 5'd2, 5'd1, 3'b000), 32'h100, 32'hFFFF_FFFF, 32'd1);
    check_beat("beq_nt", 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 32'h0000_00F8, 1'b0);
    // target wraps mod 2^32: pc=0 with imm_b=-8.
    send(enc_b(13'h1FF8, 5'd2, 5'd1, 3'b001), 32'h0, 32'd1, 32'd1);
    check_beat("bne_wrap", 32'd0, 5'd0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFF8, 1'b0);
    send(enc_b(13'h1FF8, 5'd2, 5'd1, 3'b010), 32'h100, 32'd1, 32'd1);
    check_beat("br_f3_010", 32'd0, 5'd0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);

    // Back-to-back AUIPC then LUI.
    offer(enc_u(20'h00002, 5'd1, OP_AUI), 32'd0, 32'd0);
    ins_pc = 32'h1000;
    @(negedge clk);
    chk("b2b.ready0", 32'(ins_ready), 32'd1);
    offer(enc_u(20'hABCDE, 5'd2, OP_LUI), 32'd0, 32'd0);
    @(negedge clk);
    ins_valid = 1'b0;
    chk("b2b.ready1", 32'(ins_ready), 32'd1);
    check_beat("auipc", 32'h0000_3000, 5'd1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    check_beat("lui", 32'hABCD_E000, 5'd2, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    chk("b2b.drained", 32'(res_valid), 32'd0);

    // Backpressure: three ops with res_ready=0 for three cycles.
    res_ready = 1'b0;
    offer(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd6, OP_R), 32'd1, 32'd1);
    @(negedge clk);
    offer(enc_r(7'b0, 5'd2, 5'd1, 3'b100, 5'd7, OP_R), 32'hF0F0_F0F0, 32'hFFFF_0000);
    @(negedge clk);
    offer(enc_r(7'b0, 5'd2, 5'd1, 3'b011, 5'd8, OP_R), 32'd1, 32'd2);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp.hold.data",  res_data,          32'd2);
      chk("bp.hold.rd",    32'(res_rd),       32'd6);
      chk("bp.hold.en",    32'(alu_en),       32'd0);
      chk("bp.hold.ready", 32'(ins_ready),    32'd0);
      @(negedge clk);
    end
    res_ready = 1'b1;
    #1;
    chk("bp.release.en",    32'(alu_en),    32'd1);
    chk("bp.release.ready", 32'(ins_ready), 32'd1);
    @(negedge clk);
    ins_valid = 1'b0;
    check_beat("bp.b", 32'h0F0F_F0F0, 5'd7, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    check_beat("bp.c", 32'd1, 5'd8, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    @(negedge clk);
    chk("bp.drained", 32'(res_valid), 32'd0);

    // Flush with S1 and S2 full.
    res_ready = 1'b0;
    offer(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd10, OP_R), 32'd5, 32'd5);
    @(negedge clk);
    offer(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd11, OP_R), 32'd6, 32'd6);
    @(negedge clk);
    offer(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd12, OP_R), 32'd7, 32'd7);
    chk("flush.pre.valid", 32'(res_valid), 32'd1);
    flush = 1'b1;
    #1;
    chk("flush.ready", 32'(ins_ready), 32'd0);
    chk("flush.en",    32'(alu_en),    32'd0);
    @(negedge clk);
    flush = 1'b0;
    ins_valid = 1'b0;
    chk("flush.res_valid", 32'(res_valid), 32'd0);
    chk("flush.s1_empty",  32'(alu_en),    32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("flush.after", 32'(res_valid), 32'd0);

    // Asynchronous reset mid-stream.
    res_ready = 1'b0;
    offer(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd13, OP_R), 32'd8, 32'd8);
    @(negedge clk);
    offer(enc_r(7'b0, 5'd2, 5'd1, 3'b000, 5'd14, OP_R), 32'd9, 32'd9);
    @(negedge clk);
    chk("arst.pre.valid", 32'(res_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.res_valid", 32'(res_valid), 32'd0);
    chk("arst.alu_en",    32'(alu_en),    32'd0);
    chk("arst.ins_ready", 32'(ins_ready), 32'd1);
    chk("arst.alu_a",     alu_a,          32'd0);
    ins_valid = 1'b0;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
